// File: rtl/alu_defs.sv
// alu_defs: shared definitions for the ALU arbiter slice.
//   WIDTH    operand/result width (fixed by ALU16b)
//   OP_W     ALU opcode width
//   ID_W     requester-id width
//   alu_op_t opcode encodings ALU_AND..ALU_SLT (6..7 are unassigned)
//   req_id_t requester identifiers
package alu_defs;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned OP_W  = 3;
  localparam int unsigned ID_W  = 1;

  typedef enum logic [OP_W-1:0] {
    ALU_AND = 3'd0,
    ALU_OR  = 3'd1,
    ALU_NOR = 3'd2,
    ALU_ADD = 3'd3,
    ALU_SUB = 3'd4,
    ALU_SLT = 3'd5
  } alu_op_t;

  typedef enum logic [ID_W-1:0] {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_t;

endpackage

// File: rtl/ALU16b.sv
// ALU16b: purely combinational 16-bit ALU.
//   a, b  in  WIDTH  operands
//   op    in  OP_W   opcode (alu_op_t encoding; 6..7 yield r=0)
//   r     out WIDTH  result
//   zero  out 1      r == 0
//   ovfl  out 1      signed overflow of ADD/SUB, 0 for other opcodes
module ALU16b
  import alu_defs::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] r,
  output logic             zero,
  output logic             ovfl
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             add_ovfl;
  logic             sub_ovfl;
  logic             slt;

  always_comb begin
    sum      = a + b;
    diff     = a - b;
    // Signed overflow: operands of equal (ADD) / opposite (SUB) sign and
    // the result sign differs from a.
    add_ovfl = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1]  != a[WIDTH-1]);
    sub_ovfl = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    slt      = $signed(a) < $signed(b);

    r    = '0;
    ovfl = 1'b0;
    case (op)
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_NOR: r = ~(a | b);
      ALU_ADD: begin
        r    = sum;
        ovfl = add_ovfl;
      end
      ALU_SUB: begin
        r    = diff;
        ovfl = sub_ovfl;
      end
      ALU_SLT: r = {{(WIDTH-1){1'b0}}, slt};
      default: r = '0;
    endcase
    zero = (r == '0);
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU16b between two requesters.
//   clk, reset                  clock, synchronous active-high reset
//   reqN_valid/ready            issue handshake (ready = grant, combinational)
//   reqN_a, reqN_b, reqN_op     operands and opcode
//   rspN_valid                  response held for requester N
//   rspN_r, rspN_zero, rspN_ovfl held result and flags
//   rspN_ack                    requester N consumes its held response
// Round-robin arbitration, one outstanding operation per requester,
// fixed two-cycle issue-to-result latency.
module alu_arbiter
  import alu_defs::*;
#(
  parameter int unsigned WIDTH = alu_defs::WIDTH,
  parameter int unsigned OP_W  = alu_defs::OP_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OP_W-1:0]  req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OP_W-1:0]  req1_op,
  output logic             rsp0_valid,
  output logic [WIDTH-1:0] rsp0_r,
  output logic             rsp0_zero,
  output logic             rsp0_ovfl,
  input  logic             rsp0_ack,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp1_r,
  output logic             rsp1_zero,
  output logic             rsp1_ovfl,
  input  logic             rsp1_ack
);

  req_id_t          last_grant;
  req_id_t          iss_owner;
  logic             iss_v;
  logic [WIDTH-1:0] iss_a;
  logic [WIDTH-1:0] iss_b;
  logic [OP_W-1:0]  iss_op;
  logic             pend0;
  logic             pend1;

  logic             elig0;
  logic             elig1;
  logic             grant0;
  logic             grant1;

  logic [WIDTH-1:0] alu_r;
  logic             alu_zero;
  logic             alu_ovfl;

  // pend stays set until the edge that consumes the response, so an ack
  // cycle never doubles as a re-issue cycle for the same requester.
  always_comb begin
    elig0  = req0_valid && !pend0;
    elig1  = req1_valid && !pend1;
    grant0 = !reset && elig0 && (!elig1 || (last_grant == REQ1));
    grant1 = !reset && elig1 && (!elig0 || (last_grant == REQ0));
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  ALU16b u_alu (
    .a    (iss_a),
    .b    (iss_b),
    .op   (iss_op),
    .r    (alu_r),
    .zero (alu_zero),
    .ovfl (alu_ovfl)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= REQ1;
      iss_owner  <= REQ0;
      iss_v      <= 1'b0;
      iss_a      <= '0;
      iss_b      <= '0;
      iss_op     <= '0;
      pend0      <= 1'b0;
      pend1      <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp0_r     <= '0;
      rsp0_zero  <= 1'b0;
      rsp0_ovfl  <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp1_r     <= '0;
      rsp1_zero  <= 1'b0;
      rsp1_ovfl  <= 1'b0;
    end else begin
      // Issue stage
      iss_v <= grant0 || grant1;
      if (grant0) begin
        iss_a      <= req0_a;
        iss_b      <= req0_b;
        iss_op     <= req0_op;
        iss_owner  <= REQ0;
        last_grant <= REQ0;
      end else if (grant1) begin
        iss_a      <= req1_a;
        iss_b      <= req1_b;
        iss_op     <= req1_op;
        iss_owner  <= REQ1;
        last_grant <= REQ1;
      end

      pend0 <= grant0 || (pend0 && !(rsp0_valid && rsp0_ack));
      pend1 <= grant1 || (pend1 && !(rsp1_valid && rsp1_ack));

      // Result stage: the owner's response register is empty whenever its
      // operation is in flight, so a write never collides with an ack.
      if (iss_v && (iss_owner == REQ0)) begin
        rsp0_valid <= 1'b1;
        rsp0_r     <= alu_r;
        rsp0_zero  <= alu_zero;
        rsp0_ovfl  <= alu_ovfl;
      end else if (rsp0_valid && rsp0_ack) begin
        rsp0_valid <= 1'b0;
      end

      if (iss_v && (iss_owner == REQ1)) begin
        rsp1_valid <= 1'b1;
        rsp1_r     <= alu_r;
        rsp1_zero  <= alu_zero;
        rsp1_ovfl  <= alu_ovfl;
      end else if (rsp1_valid && rsp1_ack) begin
        rsp1_valid <= 1'b0;
      end
    end
  end

endmodule
